// File: rtl/m68k_bus_sequencer.sv
// 68000 bus-cycle sequencer: region decode, SDRAM req/ack, ROM/IO wait states, nDTACK and timeout.
// nDTACK low 2 CLK after a LOCAL start, 1 CLK after ACK; REQ held until ACK or timeout.
module m68k_bus_sequencer #(
   parameter int ROM_WAIT = 1,
   parameter int IO_WAIT  = 0,
   parameter int TIMEOUT  = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CLK_EN_68K_P,
   input  logic        nAS,
   input  logic        nUDS,
   input  logic        nLDS,
   input  logic        M68K_RW,
   input  logic [22:0] M68K_ADDR,
   input  logic        ROMWAIT_EN,
   output logic        SDRAM_REQ,
   input  logic        SDRAM_ACK,
   output logic [22:0] SDRAM_ADDR,
   output logic        SDRAM_WE,
   output logic [1:0]  SDRAM_BE,
   output logic        nDTACK,
   output logic        BUS_ERR
);
   typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_WAITST, S_ASSERT} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_req, w_req_nxt;
   logic        r_dtack_n, w_dtack_n_nxt;
   logic        r_bus_err, w_bus_err_nxt;
   logic        r_abort, w_abort_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [22:0] r_addr;
   logic        r_we;
   logic [1:0]  r_be;
   logic        w_latch, w_start, w_sdram, w_rom, w_aborted;

   // Address bit 22 of the word address is byte-address bit 23.
   assign w_sdram   = M68K_ADDR[22:19] inside {4'h0, 4'h1, 4'h2, 4'hC};
   assign w_rom     = r_addr[22:19] inside {4'h0, 4'h2, 4'hC};
   assign w_start   = !nAS && (!nUDS || !nLDS);
   assign w_aborted = r_abort || nAS;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_req     <= 1'b0;
         r_dtack_n <= 1'b1;
         r_bus_err <= 1'b0;
         r_abort   <= 1'b0;
         r_cnt     <= 8'd0;
         r_addr    <= 23'd0;
         r_we      <= 1'b0;
         r_be      <= 2'b00;
      end else begin
         r_state   <= w_state_nxt;
         r_req     <= w_req_nxt;
         r_dtack_n <= w_dtack_n_nxt;
         r_bus_err <= w_bus_err_nxt;
         r_abort   <= w_abort_nxt;
         r_cnt     <= w_cnt_nxt;
         if (w_latch) begin
            r_addr <= M68K_ADDR;
            r_we   <= ~M68K_RW;
            r_be   <= {~nUDS, ~nLDS};
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_req_nxt     = r_req;
      w_dtack_n_nxt = r_dtack_n;
      w_bus_err_nxt = 1'b0;
      w_abort_nxt   = r_abort;
      w_cnt_nxt     = r_cnt;
      w_latch       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_dtack_n_nxt = 1'b1;
            w_abort_nxt   = 1'b0;
            if (w_start) begin
               w_latch = 1'b1;
               if (w_sdram) begin
                  w_state_nxt = S_MEM_WAIT;
                  w_req_nxt   = 1'b1;
                  w_cnt_nxt   = 8'd0;
               end else begin
                  w_state_nxt = S_WAITST;
                  w_cnt_nxt   = 8'(IO_WAIT);
               end
            end
         end
         S_MEM_WAIT: begin
            w_abort_nxt = w_aborted;
            if (SDRAM_ACK) begin
               w_req_nxt = 1'b0;
               w_cnt_nxt = 8'd0;
               if (w_aborted)
                  w_state_nxt = S_IDLE;
               else if (w_rom && ROMWAIT_EN && ROM_WAIT != 0) begin
                  w_state_nxt = S_WAITST;
                  w_cnt_nxt   = 8'(ROM_WAIT);
               end else
                  // No wait states owed: go straight to ASSERT so DTACK follows ACK by one CLK.
                  w_state_nxt = S_ASSERT;
            end else if (CLK_EN_68K_P) begin
               if (r_cnt == 8'(TIMEOUT - 1)) begin
                  w_req_nxt     = 1'b0;
                  w_bus_err_nxt = 1'b1;
                  w_cnt_nxt     = 8'd0;
                  if (w_aborted)
                     w_state_nxt = S_IDLE;
                  else begin
                     w_state_nxt   = S_ASSERT;
                     w_dtack_n_nxt = 1'b0;
                  end
               end else
                  w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_WAITST: begin
            if (nAS)
               w_state_nxt = S_IDLE;
            else if (r_cnt == 8'd0)
               w_state_nxt = S_ASSERT;
            else if (CLK_EN_68K_P) begin
               w_cnt_nxt = r_cnt - 8'd1;
               if (r_cnt == 8'd1)
                  w_state_nxt = S_ASSERT;
            end
         end
         S_ASSERT: begin
            if (nAS) begin
               w_dtack_n_nxt = 1'b1;
               w_state_nxt   = S_IDLE;
            end else
               w_dtack_n_nxt = 1'b0;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign SDRAM_REQ  = r_req;
   assign SDRAM_ADDR = r_addr;
   assign SDRAM_WE   = r_we;
   assign SDRAM_BE   = r_be;
   assign nDTACK     = r_dtack_n;
   assign BUS_ERR    = r_bus_err;
endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Directed bench for m68k_bus_sequencer: vector table of complete bus cycles plus hand sequences.
module tb_m68k_bus_sequencer;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        CLK_EN_68K_P = 1'b1;
   logic        nAS = 1'b1;
   logic        nUDS = 1'b1;
   logic        nLDS = 1'b1;
   logic        M68K_RW = 1'b1;
   logic [22:0] M68K_ADDR = 23'd0;
   logic        ROMWAIT_EN = 1'b0;
   logic        SDRAM_ACK = 1'b0;
   logic        SDRAM_REQ;
   logic [22:0] SDRAM_ADDR;
   logic        SDRAM_WE;
   logic [1:0]  SDRAM_BE;
   logic        nDTACK;
   logic        BUS_ERR;

   int n_err = 0;
   int n_chk = 0;

   typedef struct {
      logic [22:0] addr;
      logic        rw;
      logic        uds;
      logic        lds;
      logic        romwait;
      logic        sdram;
      int          ds_dly;
      int          ack_dly;
      logic [1:0]  be;
      logic        we;
      int          lat;
   } vec_t;

   vec_t vecs[7];

   m68k_bus_sequencer #(.ROM_WAIT(1), .IO_WAIT(0), .TIMEOUT(255)) dut (
      .CLK(CLK), .RESET(RESET), .CLK_EN_68K_P(CLK_EN_68K_P),
      .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .M68K_RW(M68K_RW),
      .M68K_ADDR(M68K_ADDR), .ROMWAIT_EN(ROMWAIT_EN),
      .SDRAM_REQ(SDRAM_REQ), .SDRAM_ACK(SDRAM_ACK), .SDRAM_ADDR(SDRAM_ADDR),
      .SDRAM_WE(SDRAM_WE), .SDRAM_BE(SDRAM_BE), .nDTACK(nDTACK), .BUS_ERR(BUS_ERR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic req_seen;
      int   lat;
      req_seen     = 1'b0;
      CLK_EN_68K_P = 1'b1;
      M68K_ADDR    = v.addr;
      M68K_RW      = v.rw;
      ROMWAIT_EN   = v.romwait;
      nAS          = 1'b0;
      nUDS         = 1'b1;
      nLDS         = 1'b1;
      for (int i = 0; i < v.ds_dly; i++) begin
         tick();
         req_seen = req_seen | SDRAM_REQ;
      end
      if (v.ds_dly > 0)
         chk($sformatf("v%0d_no_start_before_ds", idx), 32'(req_seen), 32'd0);
      nUDS = v.uds;
      nLDS = v.lds;
      tick();
      chk($sformatf("v%0d_addr", idx), 32'(SDRAM_ADDR), 32'(v.addr));
      chk($sformatf("v%0d_we", idx), 32'(SDRAM_WE), 32'(v.we));
      chk($sformatf("v%0d_be", idx), 32'(SDRAM_BE), 32'(v.be));
      chk($sformatf("v%0d_req", idx), 32'(SDRAM_REQ), 32'(v.sdram));
      M68K_ADDR = ~v.addr;
      if (v.sdram) begin
         repeat (v.ack_dly - 1) tick();
         SDRAM_ACK = 1'b1;
         tick();
         SDRAM_ACK = 1'b0;
         chk($sformatf("v%0d_req_drop", idx), 32'(SDRAM_REQ), 32'd0);
      end
      lat = 0;
      while (nDTACK && lat < 20) begin
         tick();
         lat++;
         req_seen = req_seen | SDRAM_REQ;
      end
      chk($sformatf("v%0d_dtack_latency", idx), 32'(lat), 32'(v.lat));
      if (!v.sdram)
         chk($sformatf("v%0d_req_never", idx), 32'(req_seen), 32'd0);
      chk($sformatf("v%0d_addr_stable", idx), 32'(SDRAM_ADDR), 32'(v.addr));
      nAS  = 1'b1;
      nUDS = 1'b1;
      nLDS = 1'b1;
      tick();
      chk($sformatf("v%0d_dtack_release", idx), 32'(nDTACK), 32'd1);
      tick();
   endtask

   initial begin
      logic flag;
      logic en_prev;
      logic done;
      int   en_cnt;

      // addr, rw, uds, lds, romwait, sdram, ds_dly, ack_dly, be, we, lat
      vecs[0] = '{23'h000080, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 5, 2'b11, 1'b0, 1};
      vecs[1] = '{23'h000080, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 5, 2'b11, 1'b0, 2};
      vecs[2] = '{23'h080000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 2, 2'b10, 1'b1, 1};
      vecs[3] = '{23'h180000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2'b11, 1'b0, 2};
      vecs[4] = '{23'h600000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 2'b01, 1'b0, 2};
      vecs[5] = '{23'h200000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 2'b10, 1'b1, 2};
      vecs[6] = '{23'h100040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 3, 2'b11, 1'b1, 2};

      tick();
      tick();
      chk("rst_req", 32'(SDRAM_REQ), 32'd0);
      chk("rst_dtack", 32'(nDTACK), 32'd1);
      chk("rst_addr", 32'(SDRAM_ADDR), 32'd0);
      chk("rst_we_be", 32'({SDRAM_WE, SDRAM_BE}), 32'd0);
      chk("rst_bus_err", 32'(BUS_ERR), 32'd0);
      RESET = 1'b0;
      tick();

      for (int i = 0; i < 7; i++)
         run_vec(i, vecs[i]);

      // ACK while idle must be ignored
      SDRAM_ACK = 1'b1;
      tick();
      SDRAM_ACK = 1'b0;
      tick();
      chk("idle_ack_req", 32'(SDRAM_REQ), 32'd0);
      chk("idle_ack_dtack", 32'(nDTACK), 32'd1);

      // ROM wait state only consumed on a CLK_EN_68K_P
      M68K_ADDR = 23'h000080; M68K_RW = 1'b1; ROMWAIT_EN = 1'b1;
      nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
      tick();
      CLK_EN_68K_P = 1'b0;
      SDRAM_ACK = 1'b1;
      tick();
      SDRAM_ACK = 1'b0;
      flag = 1'b0;
      repeat (4) begin
         tick();
         flag = flag | !nDTACK;
      end
      chk("romwait_hold_no_en", 32'(flag), 32'd0);
      CLK_EN_68K_P = 1'b1;
      tick();
      chk("romwait_en_edge", 32'(nDTACK), 32'd1);
      tick();
      chk("romwait_dtack", 32'(nDTACK), 32'd0);
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
      tick();
      tick();

      // Timeout with CLK_EN_68K_P every other CLK
      M68K_ADDR = 23'h080000; M68K_RW = 1'b1; ROMWAIT_EN = 1'b0;
      CLK_EN_68K_P = 1'b0;
      nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
      tick();
      chk("to_req_start", 32'(SDRAM_REQ), 32'd1);
      en_cnt = 0; done = 1'b0; flag = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         CLK_EN_68K_P = ~CLK_EN_68K_P;
         en_prev = CLK_EN_68K_P;
         tick();
         if (en_prev) en_cnt++;
         if (BUS_ERR) done = 1'b1;
         else flag = flag | !nDTACK;
      end
      chk("to_bus_err_seen", 32'(done), 32'd1);
      chk("to_en_count", 32'(en_cnt), 32'd255);
      chk("to_early_dtack", 32'(flag), 32'd0);
      chk("to_dtack", 32'(nDTACK), 32'd0);
      chk("to_req", 32'(SDRAM_REQ), 32'd0);
      tick();
      chk("to_bus_err_pulse", 32'(BUS_ERR), 32'd0);
      chk("to_dtack_held", 32'(nDTACK), 32'd0);
      CLK_EN_68K_P = 1'b1;
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
      tick();
      chk("to_dtack_release", 32'(nDTACK), 32'd1);
      tick();

      // Abort during MEM_WAIT: REQ held until ACK, no DTACK, no BUS_ERR
      M68K_ADDR = 23'h000080; M68K_RW = 1'b1;
      nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
      tick();
      tick();
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
      tick();
      chk("abort_req_held", 32'(SDRAM_REQ), 32'd1);
      tick();
      tick();
      SDRAM_ACK = 1'b1;
      tick();
      SDRAM_ACK = 1'b0;
      chk("abort_req_drop", 32'(SDRAM_REQ), 32'd0);
      chk("abort_bus_err", 32'(BUS_ERR), 32'd0);
      flag = nDTACK;
      repeat (3) begin
         tick();
         flag = flag & nDTACK;
      end
      chk("abort_no_dtack", 32'(flag), 32'd1);
      run_vec(100, vecs[3]);

      // Reset in the middle of MEM_WAIT
      M68K_ADDR = 23'h000123; M68K_RW = 1'b0;
      nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
      tick();
      tick();
      chk("mid_rst_req_before", 32'(SDRAM_REQ), 32'd1);
      RESET = 1'b1;
      tick();
      chk("mid_rst_req", 32'(SDRAM_REQ), 32'd0);
      chk("mid_rst_dtack", 32'(nDTACK), 32'd1);
      chk("mid_rst_addr", 32'(SDRAM_ADDR), 32'd0);
      chk("mid_rst_we_be", 32'({SDRAM_WE, SDRAM_BE}), 32'd0);
      chk("mid_rst_bus_err", 32'(BUS_ERR), 32'd0);
      RESET = 1'b0;
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; M68K_RW = 1'b1;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
